// File: rtl/trigger_pkg.sv
// trigger_pkg: shared state encoding and default sizes for the trigger capture block
package trigger_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_FILL = 3'd1,
        ARMED    = 3'd2,
        POST     = 3'd3,
        READOUT  = 3'd4
    } state_t;
endpackage

// File: rtl/trigger_capture_if.sv
// trigger_capture_if: valid/ready readout stream towards the DMA/packetiser
interface trigger_capture_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    modport master (output m_data, m_valid, m_last, input m_ready);
    modport slave (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample buffer, one write port and one registered read port
module capture_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  adc_clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    // write port
    always_ff @(posedge adc_clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // registered read port, one cycle latency
    always_ff @(posedge adc_clk) begin
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: pre/post trigger ring capture with a skid-buffered valid/ready readout
module trigger_capture
    import trigger_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  adc_clk,
    input  logic                  trig_reset,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_valid,
    input  logic                  trigger_in,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] pre_samples,
    input  logic [ADDR_WIDTH-1:0] post_samples,
    trigger_capture_if.master     m,
    output logic                  capture_busy,
    output logic                  capture_done,
    output logic                  trig_early
);
    localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ONE_W = (ADDR_WIDTH+1)'(1);

    state_t                state, state_nx;
    logic                  trig_d, trig_edge, we, re, pop, last_pop;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_addr, p_len, pre_cnt;
    logic [ADDR_WIDTH:0]   q_len, n_len, post_cnt, rd_cnt, pre_w, q_raw, q_arm;
    logic                  rd_valid, rd_last, out_v, out_l, sk_v, sk_l;
    logic [DATA_WIDTH-1:0] ram_q, out_d, sk_d;

    assign trig_edge = trigger_in & ~trig_d;
    assign we        = adc_valid && (state == PRE_FILL || state == ARMED || state == POST);
    assign pop       = out_v & m.m_ready;
    assign last_pop  = state == READOUT && pop && out_l;
    // a read may issue only if its word, arriving next cycle, is guaranteed a free slot
    assign re        = state == READOUT && rd_cnt < n_len &&
                       (2'(out_v) + 2'(sk_v) + 2'(rd_valid) <= (pop ? 2'd2 : 2'd1));
    // post length is at least one word and the window never exceeds the buffer
    assign pre_w     = {1'b0, pre_samples};
    assign q_raw     = (post_samples == '0) ? ONE_W : {1'b0, post_samples};
    assign q_arm     = (pre_w + q_raw > DEPTH) ? DEPTH - pre_w : q_raw;

    assign capture_busy = state != IDLE;
    assign m.m_data     = out_d;
    assign m.m_valid    = out_v;
    assign m.m_last     = out_l;

    capture_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .adc_clk (adc_clk),
        .we      (we),
        .waddr   (wr_ptr),
        .wdata   (adc_data),
        .re      (re),
        .raddr   (rd_addr),
        .rdata   (ram_q)
    );

    // state register
    always_ff @(posedge adc_clk) begin
        state <= trig_reset ? IDLE : state_nx;
    end

    // next-state: pre-fill, wait for trigger, collect post words, drain window
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:     state_nx = arm ? ((pre_samples == '0) ? ARMED : PRE_FILL) : IDLE;
            PRE_FILL: state_nx = (we && pre_cnt + ONE_A == p_len) ? ARMED : PRE_FILL;
            ARMED:    state_nx = trig_edge ? ((we && q_len == ONE_W) ? READOUT : POST) : ARMED;
            POST:     state_nx = (we && post_cnt + ONE_W == q_len) ? READOUT : POST;
            READOUT:  state_nx = last_pop ? IDLE : READOUT;
            default:  state_nx = IDLE;
        endcase
    end

    // capture bookkeeping: pointers, lengths, counters and status flags
    always_ff @(posedge adc_clk) begin
        if (trig_reset) begin
            wr_ptr       <= '0;
            trig_d       <= 1'b0;
            trig_early   <= 1'b0;
            capture_done <= 1'b0;
            rd_cnt       <= '0;
        end else begin
            trig_d       <= trigger_in;
            capture_done <= last_pop;
            if (we) wr_ptr <= wr_ptr + ONE_A;
            if (state == IDLE && arm) begin
                p_len      <= pre_samples;
                q_len      <= q_arm;
                n_len      <= pre_w + q_arm;
                pre_cnt    <= '0;
                trig_early <= 1'b0;
            end
            if (state == PRE_FILL && we) pre_cnt <= pre_cnt + ONE_A;
            if (state == PRE_FILL && trig_edge) trig_early <= 1'b1;
            if (state == ARMED && trig_edge) begin
                rd_addr  <= wr_ptr - p_len;
                rd_cnt   <= '0;
                post_cnt <= we ? ONE_W : '0;
            end
            if (state == POST && we) post_cnt <= post_cnt + ONE_W;
            if (re) begin
                rd_addr <= rd_addr + ONE_A;
                rd_cnt  <= rd_cnt + ONE_W;
            end
        end
    end

    // readout pipeline: RAM word lands in the output register, or in the skid when stalled
    always_ff @(posedge adc_clk) begin
        if (trig_reset) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            out_v    <= 1'b0;
            out_l    <= 1'b0;
            sk_v     <= 1'b0;
            sk_l     <= 1'b0;
        end else begin
            rd_valid <= re;
            rd_last  <= re && rd_cnt == n_len - ONE_W;
            if (!out_v || pop) begin
                out_v <= sk_v | rd_valid;
                out_d <= sk_v ? sk_d : ram_q;
                out_l <= sk_v ? sk_l : rd_last;
                sk_v  <= sk_v & rd_valid;
            end else if (rd_valid) begin
                sk_v <= 1'b1;
            end
            if (rd_valid) begin
                sk_d <= ram_q;
                sk_l <= rd_last;
            end
        end
    end
endmodule
